demux_1x2_8bits: RTL and testbench

- Splits one 8-bit valid-qualified byte stream into two lanes, distributing accepted bytes round-robin (lane 0, lane 1, lane 0, ...).
- Inverse of the 2x1 8-bit lane mux: sits on the transmit side ahead of the per-lane serializers, and feeds the mux directly in loopback benches.
- Each lane has a small FIFO so a stalled lane back-pressures the input without losing bytes.

---
 rtl/demux_1x2_8bits.sv | 125 ++++++++++++
 tb/tb_demux_1x2_8bits.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_8bits.sv
// 1-to-2 byte-lane demultiplexer: accepted bytes alternate lane 0 / lane 1, each lane buffered by a DEPTH-entry FIFO.
// Optional DEMUX_IDLE_RESYNC_EN: after IDLE_LIMIT idle input cycles the lane pointer returns to lane 0.
module demux_1x2_8bits #(
  parameter int DEPTH      = 4,
  parameter int IDLE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out0,
  output logic       valid_out0,
  input  logic       ready0,
  output logic [7:0] out1,
  output logic       valid_out1,
  input  logic       ready1,
  output logic       sel
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IDLE_LIMIT < 1) begin : g_bad_param
    $error("demux_1x2_8bits: DEPTH must be a power of 2 >= 2 and IDLE_LIMIT >= 1");
  end

  logic [7:0]    mem_q [2][DEPTH];
  logic [7:0]    mem_d [2][DEPTH];
  logic [AW-1:0] rd_q  [2];
  logic [AW-1:0] rd_d  [2];
  logic [AW-1:0] wr_q  [2];
  logic [AW-1:0] wr_d  [2];
  logic [AW:0]   cnt_q [2];
  logic [AW:0]   cnt_d [2];
  logic [7:0]    out_q [2];
  logic [7:0]    out_d [2];
  logic          sel_q;
  logic          sel_d;
  logic [1:0]    lane_ready;
  logic          accept;

`ifdef DEMUX_IDLE_RESYNC_EN
  localparam int IW = $clog2(IDLE_LIMIT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_LIMIT);
  logic [IW-1:0] idle_q;
  logic [IW-1:0] idle_d;
`endif

  assign lane_ready = {ready1, ready0};
  // Depends only on registered state, so no in_valid -> in_ready path exists.
  assign in_ready   = (cnt_q[sel_q] != FULL_CNT);
  assign accept     = in_valid && in_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latches).
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    out_d = out_q;
    sel_d = accept ? ~sel_q : sel_q;

    for (int i = 0; i < 2; i++) begin
      logic push;
      logic pop;
      push = accept && (sel_q == 1'(i));
      pop  = (cnt_q[i] != '0) && lane_ready[i];
      if (push) begin
        mem_d[i][wr_q[i]] = in_data;
        wr_d[i]           = wr_q[i] + 1'b1;
      end
      if (pop) rd_d[i] = rd_q[i] + 1'b1;
      if (push && !pop)      cnt_d[i] = cnt_q[i] + 1'b1;
      else if (pop && !push) cnt_d[i] = cnt_q[i] - 1'b1;
      // The output register tracks the post-edge head; an emptied lane keeps showing its last byte.
      if (cnt_d[i] != '0) out_d[i] = mem_d[i][rd_d[i]];
    end

`ifdef DEMUX_IDLE_RESYNC_EN
    if (in_valid)               idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
    else                         idle_d = idle_q;
    if (idle_d == IDLE_MAX) sel_d = 1'b0;
`endif
  end

  // NOTE: storage is not reset; entry validity comes solely from the reset-cleared counts.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 2; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
        out_q[i] <= 8'h00;
      end
      sel_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      sel_q <= sel_d;
    end
  end

`ifdef DEMUX_IDLE_RESYNC_EN
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) idle_q <= '0;
    else          idle_q <= idle_d;
  end
`endif

  assign out0       = out_q[0];
  assign out1       = out_q[1];
  assign valid_out0 = (cnt_q[0] != '0);
  assign valid_out1 = (cnt_q[1] != '0);
  assign sel        = sel_q;

endmodule

// File: tb/tb_demux_1x2_8bits.sv
// Scoreboard bench for demux_1x2_8bits: stimulus pushes expected bytes into per-lane queues, a monitor pops and compares.
// Honours DEMUX_IDLE_RESYNC_EN in its reference model.
module tb_demux_1x2_8bits;

  localparam int DEPTH      = 4;
  localparam int IDLE_LIMIT = 8;

  logic       clk = 1'b0;
  logic       reset_L = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out0, out1;
  logic       valid_out0, valid_out1;
  logic       ready0 = 1'b0;
  logic       ready1 = 1'b0;
  logic       sel;

  demux_1x2_8bits #(.DEPTH(DEPTH), .IDLE_LIMIT(IDLE_LIMIT)) dut (
    .clk(clk), .reset_L(reset_L),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out0(out0), .valid_out0(valid_out0), .ready0(ready0),
    .out1(out1), .valid_out1(valid_out1), .ready1(ready1),
    .sel(sel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: lane contents as queues, next-lane pointer, last byte shown per lane.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         sel_m = 1'b0;
  logic [7:0] last0 = 8'h00;
  logic [7:0] last1 = 8'h00;
  int         idle_m = 0;
  logic [7:0] src = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lane_size(input bit lane);
    return lane ? q1.size() : q0.size();
  endfunction

  // One clock cycle: drive at negedge, fold the edge's effect into the model just after the posedge.
  task automatic cyc(input bit v, input bit r0, input bit r1, output bit acc);
    @(negedge clk);
    in_valid = v;
    in_data  = src;
    ready0   = r0;
    ready1   = r1;
    acc = v && (lane_size(sel_m) < DEPTH);
    @(posedge clk);
    #1;
    if (acc) begin
      if (sel_m) q1.push_back(in_data);
      else       q0.push_back(in_data);
      sel_m = ~sel_m;
    end
`ifdef DEMUX_IDLE_RESYNC_EN
    if (v) idle_m = 0;
    else if (idle_m < IDLE_LIMIT) idle_m++;
    if (idle_m == IDLE_LIMIT) sel_m = 1'b0;
`endif
  endtask

  task automatic send(input logic [7:0] d, input bit r0, input bit r1);
    bit acc;
    src = d;
    for (int t = 0; t < 100; t++) begin
      cyc(1'b1, r0, r1, acc);
      if (acc) return;
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input bit r0, input bit r1);
    bit acc;
    for (int t = 0; t < n; t++) cyc(1'b0, r0, r1, acc);
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 50 && (q0.size() + q1.size()) != 0; t++) cyc(1'b0, 1'b1, 1'b1, acc);
    idle(2, 1'b1, 1'b1);
    check("drain_left", q0.size() + q1.size(), 0);
    check("drain_valid0", valid_out0, 1'b0);
    check("drain_valid1", valid_out1, 1'b0);
  endtask

  // Asserted mid-cycle to exercise the asynchronous path.
  task automatic do_reset();
    #2;
    reset_L  = 1'b0;
    in_valid = 1'b0;
    ready0   = 1'b0;
    ready1   = 1'b0;
    #1;
    check("rst_valid0", valid_out0, 1'b0);
    check("rst_valid1", valid_out1, 1'b0);
    check("rst_sel", sel, 1'b0);
    check("rst_out0", out0, 8'h00);
    check("rst_out1", out1, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);
    q0.delete();
    q1.delete();
    sel_m  = 1'b0;
    last0  = 8'h00;
    last1  = 8'h00;
    idle_m = 0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_L = 1'b1;
  endtask

  // Monitor: samples just before each rising edge, pops the scoreboard when a lane handshakes.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      check("sel", sel, sel_m);
      check("in_ready", in_ready, lane_size(sel_m) < DEPTH);
      check("valid_out0", valid_out0, q0.size() != 0);
      check("valid_out1", valid_out1, q1.size() != 0);
      if (q0.size() != 0) check("out0", out0, q0[0]);
      else                check("out0_hold", out0, last0);
      if (q1.size() != 0) check("out1", out1, q1[0]);
      else                check("out1_hold", out1, last1);
      if (valid_out0 && ready0 && q0.size() != 0) last0 = q0.pop_front();
      if (valid_out1 && ready1 && q1.size() != 0) last1 = q1.pop_front();
    end
  end

  initial begin
    bit acc;
    int src_i;
    do_reset();

    // Basic round-robin.
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b1, 1'b1);
    idle(3, 1'b1, 1'b1);
    check("t1_sel_end", sel, 1'b0);

    // Lane 1 stalled: fills with 11,13,15,17; 18 lands in lane 0, 19 waits.
    src_i = 0;
    for (int t = 0; t < 24; t++) begin
      src = 8'h10 + 8'(src_i);
      cyc(src_i < 16, 1'b1, 1'b0, acc);
      if (acc) src_i++;
    end
    check("t2_stall_in_ready", in_ready, 1'b0);
    check("t2_stall_sel", sel, 1'b1);
    check("t2_lane1_head", out1, 8'h11);
    check("t2_next_byte", src_i, 9);
    for (int t = 0; t < 60 && src_i < 16; t++) begin
      src = 8'h10 + 8'(src_i);
      cyc(1'b1, 1'b1, 1'b1, acc);
      if (acc) src_i++;
    end
    check("t2_all_sent", src_i, 16);
    drain();

    // Simultaneous push/pop on lane 0 holding two entries.
    send(8'h31, 1'b0, 1'b0);
    send(8'h32, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    check("t3_head_before", out0, 8'h31);
    send(8'h35, 1'b1, 1'b0);
    check("t3_valid_after", valid_out0, 1'b1);
    check("t3_head_after", out0, 8'h33);
    drain();
    check("t3_last_out0", out0, 8'h35);

    // Reset with three bytes buffered.
    send(8'h41, 1'b0, 1'b0);
    send(8'h42, 1'b0, 1'b0);
    send(8'h43, 1'b0, 1'b0);
    do_reset();
    send(8'h55, 1'b0, 1'b0);
    check("t4_out0_55", out0, 8'h55);
    check("t4_valid0_55", valid_out0, 1'b1);
    drain();

    // Idle gap before a new burst.
    do_reset();
    send(8'hC0, 1'b1, 1'b1);
    send(8'hC1, 1'b1, 1'b1);
    send(8'hC2, 1'b1, 1'b1);
    idle(IDLE_LIMIT, 1'b0, 1'b0);
`ifdef DEMUX_IDLE_RESYNC_EN
    check("t5_sel_after_idle", sel, 1'b0);
`else
    check("t5_sel_after_idle", sel, 1'b1);
`endif
    send(8'hC3, 1'b0, 1'b0);
    drain();

    // Random traffic with random back-pressure.
    src = 8'($urandom);
    for (int t = 0; t < 1000; t++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      if (acc) src = 8'($urandom);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
